led_pattern_sequencer: RTL and testbench

Run-time controller for the 3-bit LED shift-pattern datapath, placed between the top-level board logic and the LED pins. It loads a seed pattern, then steps it at a programmable period by rotation, or by bounce when that mode is compiled in. It also supports start, pause/resume and stop control, plus step and wrap status for debug.

---
 rtl/led_seq_pkg.sv | 15 +
 rtl/led_pattern_sequencer_if.sv | 29 ++
 rtl/led_seq_prescaler.sv | 36 +++
 rtl/led_pattern_sequencer.sv | 165 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the LED pattern sequencer.
package led_seq_pkg;

    localparam int LED_WIDTH = 3;   // default pattern width
    localparam int LED_DIV_W = 24;  // default step-period field width
    localparam int WRAP_W    = 8;   // wrap/reversal counter width

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        HOLD
    } state_e;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control/status bundle between the board logic (master) and the
// LED pattern sequencer (slave).
interface led_pattern_sequencer_if
    import led_seq_pkg::*;
#(
    parameter int WIDTH = LED_WIDTH,
    parameter int DIV_W = LED_DIV_W
);
    logic              start_i;
    logic              stop_i;
    logic [WIDTH-1:0]  first_value_i;
    logic [DIV_W-1:0]  div_i;
    logic              dir_i;
    logic              mode_i;
    logic [WIDTH-1:0]  led_o;
    logic              step_o;
    logic              busy_o;
    logic [WRAP_W-1:0] wrap_cnt_o;

    modport master (
        output start_i, stop_i, first_value_i, div_i, dir_i, mode_i,
        input  led_o, step_o, busy_o, wrap_cnt_o
    );

    modport slave (
        input  start_i, stop_i, first_value_i, div_i, dir_i, mode_i,
        output led_o, step_o, busy_o, wrap_cnt_o
    );
endinterface

// File: rtl/led_seq_prescaler.sv
// Step-period prescaler: counts 0..div-1 while enabled and raises tick
// on the last count. Clear has priority and holds the count at zero.
module led_seq_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk_in1,
    input  logic             ext_reset_in_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,   // must be >= 1
    output logic             tick_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Next count and terminal-count tick.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q;
        tick_o = en_i && (cnt_q == div_i - DIV_W'(1));
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_in1 or negedge ext_reset_in_n) begin
        if (!ext_reset_in_n) begin
            cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: loads a seed, then rotates it one position every
// div cycles, with start / pause / resume / stop control.
// Optional bounce mode (logical shift that reverses at the ends) is built
// only when the macro LED_SEQ_BOUNCE_EN is defined.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH = LED_WIDTH,
    parameter int DIV_W = LED_DIV_W
) (
    input logic                    clk_in1,
    input logic                    ext_reset_in_n,
    led_pattern_sequencer_if.slave bus
);
    localparam int             SC_W    = $clog2(WIDTH);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   led_q, led_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               dir_q, dir_d;
    logic [WRAP_W-1:0]  wrap_q, wrap_d;
    logic [SC_W-1:0]    sc_q, sc_d;      // rotate step counter, 0..WIDTH-1
    logic               step_q, step_d;
`ifdef LED_SEQ_BOUNCE_EN
    logic               mode_q, mode_d;
`else
    logic               unused_mode;
    assign unused_mode = bus.mode_i;
`endif

    logic               presc_clr, presc_en, tick;
    logic [WIDTH-1:0]   rot_led;
    logic [SC_W-1:0]    rot_sc;
    logic [WRAP_W-1:0]  rot_wrap;

    led_seq_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk_in1        (clk_in1),
        .ext_reset_in_n (ext_reset_in_n),
        .clr_i          (presc_clr),
        .en_i           (presc_en),
        .div_i          (div_q),
        .tick_o         (tick)
    );

    // Rotate step candidate and its wrap bookkeeping.
    always_comb begin
        rot_led  = dir_q ? {led_q[0], led_q[WIDTH-1:1]} : {led_q[WIDTH-2:0], led_q[WIDTH-1]};
        rot_sc   = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);
        rot_wrap = (sc_q == SC_LAST) ? wrap_q + WRAP_W'(1) : wrap_q;
    end

    // Control FSM and pattern datapath next state.
    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        div_d     = div_q;
        dir_d     = dir_q;
        wrap_d    = wrap_q;
        sc_d      = sc_q;
        step_d    = 1'b0;
        presc_clr = 1'b0;
        presc_en  = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
        mode_d    = mode_q;
`endif
        unique case (state_q)
            IDLE: begin
                presc_clr = 1'b1;
                // Seed and configuration are captured on the edge into LOAD
                // so the seed is already on led_o during the LOAD cycle.
                if (bus.start_i && !bus.stop_i) begin
                    state_d = LOAD;
                    led_d   = (bus.first_value_i == '0) ? WIDTH'(1) : bus.first_value_i;
                    div_d   = (bus.div_i == '0) ? DIV_W'(1) : bus.div_i;
                    dir_d   = bus.dir_i;
                    wrap_d  = '0;
                    sc_d    = '0;
`ifdef LED_SEQ_BOUNCE_EN
                    mode_d  = bus.mode_i;
`endif
                end
            end
            LOAD: begin
                presc_clr = 1'b1;
                state_d   = bus.stop_i ? HOLD : RUN;
            end
            RUN: begin
                presc_en = 1'b1;
                // A tick in the same cycle as stop still completes its step.
                if (tick) begin
                    step_d = 1'b1;
                    led_d  = rot_led;
                    sc_d   = rot_sc;
                    wrap_d = rot_wrap;
`ifdef LED_SEQ_BOUNCE_EN
                    if (mode_q) begin
                        sc_d   = sc_q;
                        wrap_d = wrap_q;
                        if (led_q[WIDTH-1] && led_q[0]) begin
                            led_d = led_q;
                        end else if (!dir_q && led_q[WIDTH-1]) begin
                            led_d  = {1'b0, led_q[WIDTH-1:1]};
                            dir_d  = 1'b1;
                            wrap_d = wrap_q + WRAP_W'(1);
                        end else if (!dir_q) begin
                            led_d = {led_q[WIDTH-2:0], 1'b0};
                        end else if (led_q[0]) begin
                            led_d  = {led_q[WIDTH-2:0], 1'b0};
                            dir_d  = 1'b0;
                            wrap_d = wrap_q + WRAP_W'(1);
                        end else begin
                            led_d = {1'b0, led_q[WIDTH-1:1]};
                        end
                    end
`endif
                end
                if (bus.stop_i) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.stop_i) begin
                    state_d = IDLE;
                    led_d   = '0;
                end else if (bus.start_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pattern and status registers.
    always_ff @(posedge clk_in1 or negedge ext_reset_in_n) begin
        if (!ext_reset_in_n) begin
            state_q <= IDLE;
            led_q   <= '0;
            div_q   <= DIV_W'(1);
            dir_q   <= 1'b0;
            wrap_q  <= '0;
            sc_q    <= '0;
            step_q  <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            sc_q    <= sc_d;
            step_q  <= step_d;
`ifdef LED_SEQ_BOUNCE_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign bus.led_o      = led_q;
    assign bus.step_o     = step_q;
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.wrap_cnt_o = wrap_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: the driver pushes each
// predicted step (cycle, pattern, wrap count) into a queue and a monitor
// pops and compares whenever step_o is high.
module tb_led_pattern_sequencer;
    localparam int W    = 3;
    localparam int DW   = 24;
    localparam int MASK = (1 << W) - 1;

    typedef struct {
        int cyc;
        int led;
        int wrap;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Reference model state
    int model_led, model_dir, model_mode, model_wrap, model_div, run_cnt, rot_cnt;

    led_pattern_sequencer_if #(.WIDTH(W), .DIV_W(DW)) bus ();

    led_pattern_sequencer #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk_in1        (clk),
        .ext_reset_in_n (rst_n),
        .bus            (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // One pattern step from the behavioural rules.
    task automatic model_step();
        int msb, lsb;
        msb = (model_led >> (W - 1)) & 1;
        lsb = model_led & 1;
        if (model_mode != 0) begin
            if (msb == 1 && lsb == 1) begin
                model_led = model_led;
            end else if (model_dir == 0) begin
                if (msb == 1) begin
                    model_led  = model_led >> 1;
                    model_dir  = 1;
                    model_wrap = (model_wrap + 1) % 256;
                end else begin
                    model_led = (model_led << 1) & MASK;
                end
            end else begin
                if (lsb == 1) begin
                    model_led  = (model_led << 1) & MASK;
                    model_dir  = 0;
                    model_wrap = (model_wrap + 1) % 256;
                end else begin
                    model_led = model_led >> 1;
                end
            end
        end else begin
            if (model_dir == 0) model_led = ((model_led << 1) | (model_led >> (W - 1))) & MASK;
            else                model_led = ((model_led >> 1) | (lsb << (W - 1))) & MASK;
            rot_cnt++;
            if (rot_cnt % W == 0) model_wrap = (model_wrap + 1) % 256;
        end
    endtask

    // Account for RUN cycles first..last; a step lands every model_div RUN
    // cycles and becomes visible the cycle after its last counted cycle.
    task automatic push_run(input int first, input int last);
        exp_t e;
        for (int c = first; c <= last; c++) begin
            run_cnt++;
            if (run_cnt % model_div == 0) begin
                model_step();
                e.cyc  = c + 1;
                e.led  = model_led;
                e.wrap = model_wrap;
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: compare every presented step against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.step_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_step", int'(bus.step_o), 0);
            end else begin
                e = exp_q.pop_front();
                check("step_cycle", cyc, e.cyc);
                check("step_led", int'(bus.led_o), e.led);
                check("step_wrap", int'(bus.wrap_cnt_o), e.wrap);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check("missed_step", int'(bus.step_o), 1);
        end
    end

    // Advance to 1 time unit after the edge that starts cycle c.
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scramble();
        bus.first_value_i = W'($urandom);
        bus.div_i         = DW'($urandom_range(1, 9));
        bus.dir_i         = 1'($urandom);
        bus.mode_i        = 1'($urandom);
    endtask

    // Load, run, pause, resume, pause, stop.
    task automatic trial(input int seed, input int div, input int dir, input int mode,
                         input int pre_len, input int hold_len, input int post_len,
                         input int both1, input int both2);
        int k, m, r, m2, q, load_exp;
        wait_until(cyc + 1);
        k = cyc;
        bus.start_i       = 1'b1;
        bus.stop_i        = 1'b0;
        bus.first_value_i = W'(seed);
        bus.div_i         = DW'(div);
        bus.dir_i         = dir[0];
        bus.mode_i        = mode[0];
        load_exp   = ((seed & MASK) == 0) ? 1 : (seed & MASK);
        model_led  = load_exp;
        model_div  = (div == 0) ? 1 : div;
        model_dir  = dir & 1;
`ifdef LED_SEQ_BOUNCE_EN
        model_mode = mode & 1;
`else
        model_mode = 0;
`endif
        model_wrap = 0;
        run_cnt    = 0;
        rot_cnt    = 0;
        m = k + 1 + pre_len;
        push_run(k + 2, m);

        wait_until(k + 1);
        bus.start_i = 1'b0;
        scramble();
        check("load_led", int'(bus.led_o), load_exp);
        check("load_busy", int'(bus.busy_o), 1);
        check("load_wrap", int'(bus.wrap_cnt_o), 0);

        wait_until(m);
        bus.stop_i  = 1'b1;
        bus.start_i = both1[0];
        wait_until(m + 1);
        bus.stop_i  = 1'b0;
        bus.start_i = 1'b0;
        check("hold_busy", int'(bus.busy_o), 1);

        r = m + hold_len;
        wait_until(r);
        check("hold_led", int'(bus.led_o), model_led);
        check("hold_step", int'(bus.step_o), 0);
        check("hold_wrap", int'(bus.wrap_cnt_o), model_wrap);
        m2 = r + post_len;
        push_run(r + 1, m2);
        bus.start_i = 1'b1;
        wait_until(r + 1);
        bus.start_i = 1'b0;

        wait_until(m2);
        bus.stop_i  = 1'b1;
        bus.start_i = both2[0];
        wait_until(m2 + 1);
        bus.stop_i  = 1'b0;
        bus.start_i = 1'b0;

        q = m2 + 3;
        wait_until(q);
        check("hold2_led", int'(bus.led_o), model_led);
        check("hold2_busy", int'(bus.busy_o), 1);
        bus.stop_i  = 1'b1;
        bus.start_i = 1'($urandom);
        wait_until(q + 1);
        bus.stop_i  = 1'b0;
        bus.start_i = 1'b0;
        check("idle_led", int'(bus.led_o), 0);
        check("idle_busy", int'(bus.busy_o), 0);
        wait_until(q + 4);
        check("idle_step", int'(bus.step_o), 0);
    endtask

    // Asynchronous reset in the middle of a div=1 run.
    task automatic reset_mid_run();
        int k;
        wait_until(cyc + 1);
        k = cyc;
        bus.start_i       = 1'b1;
        bus.first_value_i = W'(1);
        bus.div_i         = DW'(1);
        bus.dir_i         = 1'b0;
        bus.mode_i        = 1'b0;
        model_led  = 1;
        model_div  = 1;
        model_dir  = 0;
        model_mode = 0;
        model_wrap = 0;
        run_cnt    = 0;
        rot_cnt    = 0;
        push_run(k + 2, k + 8);
        wait_until(k + 1);
        bus.start_i = 1'b0;
        wait_until(k + 8);
        check("pre_reset_wrap", int'(bus.wrap_cnt_o), 2);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_led", int'(bus.led_o), 0);
        check("rst_step", int'(bus.step_o), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_wrap", int'(bus.wrap_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_until(cyc + 6);
        check("post_rst_busy", int'(bus.busy_o), 0);
        check("post_rst_led", int'(bus.led_o), 0);
    endtask

    initial begin
        int divs[6] = '{0, 1, 2, 3, 4, 7};
        bus.start_i       = 1'b0;
        bus.stop_i        = 1'b0;
        bus.first_value_i = '0;
        bus.div_i         = '0;
        bus.dir_i         = 1'b0;
        bus.mode_i        = 1'b0;
        #12;
        check("reset_led", int'(bus.led_o), 0);
        check("reset_step", int'(bus.step_o), 0);
        check("reset_busy", int'(bus.busy_o), 0);
        check("reset_wrap", int'(bus.wrap_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_until(cyc + 3);
        check("idle_after_reset", int'(bus.busy_o), 0);

        trial(6, 4, 0, 0, 12, 5, 9, 0, 1);   // 110 left div 4
        trial(0, 1, 1, 0, 3, 4, 6, 1, 0);    // zero seed, div 1, right
        trial(3, 8, 0, 0, 12, 20, 10, 0, 1); // stop at prescaler 3
`ifdef LED_SEQ_BOUNCE_EN
        trial(1, 2, 0, 1, 10, 3, 8, 0, 0);   // bounce 001 left div 2
`endif
        for (int i = 0; i < 25; i++) begin
            trial(int'($urandom_range(0, 7)), divs[$urandom_range(0, 5)],
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(1, 30)), int'($urandom_range(2, 20)),
                  int'($urandom_range(1, 30)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)));
        end

        reset_mid_run();
        wait_until(cyc + 5);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
